// File: rtl/dct_t2_sequencer.sv
// Frames a serial sample stream into 4-sample blocks for the dct_t2 core, waits out
// the core latency, then streams the four coefficients back out with valid/ready.
module dct_t2_sequencer #(
  parameter int WIDTH       = 16,
  parameter int DCT_LATENCY = 2,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [WIDTH-1:0]       dct_sample0,
  output logic [WIDTH-1:0]       dct_sample1,
  output logic [WIDTH-1:0]       dct_sample2,
  output logic [WIDTH-1:0]       dct_sample3,
  input  logic [WIDTH-1:0]       dct_out0,
  input  logic [WIDTH-1:0]       dct_out1,
  input  logic [WIDTH-1:0]       dct_out2,
  input  logic [WIDTH-1:0]       dct_out3,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_DRAIN} state_t;

  state_t                 state, next_state;
  logic [1:0]             fill_idx, drain_idx;
  logic [3:0]             wait_cnt;
  logic [WIDTH-1:0]       sample_q [4];
  logic [WIDTH-1:0]       result_q [4];
  logic [FRAME_CNT_W-1:0] frame_count_q;
  logic                   accept, xfer, capture;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = (state == ST_FILL);
    out_valid  = (state == ST_DRAIN);
    busy       = (state != ST_FILL);
    out_last   = (state == ST_DRAIN) && (drain_idx == 2'd3);
    // abort outranks any same-cycle handshake, so it masks all three strobes
    accept     = in_valid && in_ready && !abort;
    xfer       = out_valid && out_ready && !abort;
    capture    = (state == ST_WAIT) && (wait_cnt == 4'd0) && !abort;

    if (abort) begin
      next_state = ST_FILL;
    end else begin
      case (state)
        ST_FILL:  if (accept && fill_idx == 2'd3) next_state = ST_WAIT;
        ST_WAIT:  if (capture)                    next_state = ST_DRAIN;
        ST_DRAIN: if (xfer && drain_idx == 2'd3)  next_state = ST_FILL;
        default:                                  next_state = ST_FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_FILL;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_idx      <= 2'd0;
      drain_idx     <= 2'd0;
      wait_cnt      <= 4'd0;
      frame_count_q <= '0;
      for (int i = 0; i < 4; i++) begin
        sample_q[i] <= '0;
        result_q[i] <= '0;
      end
    end else if (abort) begin
      fill_idx  <= 2'd0;
      drain_idx <= 2'd0;
    end else begin
      if (accept) begin
        sample_q[fill_idx] <= in_data;
        fill_idx           <= fill_idx + 2'd1;
        if (fill_idx == 2'd3) wait_cnt <= 4'(DCT_LATENCY - 1);
      end
      if (state == ST_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (capture) begin
        result_q[0] <= dct_out0;
        result_q[1] <= dct_out1;
        result_q[2] <= dct_out2;
        result_q[3] <= dct_out3;
        drain_idx   <= 2'd0;
      end
      if (xfer) begin
        drain_idx <= drain_idx + 2'd1;
        if (drain_idx == 2'd3) frame_count_q <= frame_count_q + FRAME_CNT_W'(1);
      end
    end
  end

  assign dct_sample0 = sample_q[0];
  assign dct_sample1 = sample_q[1];
  assign dct_sample2 = sample_q[2];
  assign dct_sample3 = sample_q[3];
  assign out_data    = result_q[drain_idx];
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_dct_t2_sequencer.sv
// Bench for dct_t2_sequencer: table-driven frames, hand-written abort/reset sequences
// and a randomized run, all checked against a timeline/queue model of the sequencer.
module tb_dct_t2_sequencer;
  localparam int W   = 16;
  localparam int L   = 2;
  localparam int FCW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   in_data;
  logic           in_valid, in_ready, abort;
  logic [W-1:0]   dct_sample0, dct_sample1, dct_sample2, dct_sample3;
  logic [W-1:0]   dct_out0, dct_out1, dct_out2, dct_out3;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready, out_last, busy;
  logic [FCW-1:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dct_t2_sequencer #(.WIDTH(W), .DCT_LATENCY(L), .FRAME_CNT_W(FCW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .dct_sample0(dct_sample0), .dct_sample1(dct_sample1),
    .dct_sample2(dct_sample2), .dct_sample3(dct_sample3), .dct_out0(dct_out0),
    .dct_out1(dct_out1), .dct_out2(dct_out2), .dct_out3(dct_out3), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .frame_count(frame_count)
  );

  // Core stub: out_k = sample(3-k); one register here plus the sample register gives L=2 edges.
  logic [W-1:0] stub [4] = '{default: '0};
  always @(posedge clk) stub <= '{dct_sample0, dct_sample1, dct_sample2, dct_sample3};
  assign dct_out0 = stub[3];
  assign dct_out1 = stub[2];
  assign dct_out2 = stub[1];
  assign dct_out3 = stub[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames of 4 accepted samples become reversed coefficient queues that
  // become visible L+1 negedges after the accepting negedge.
  logic [W-1:0] pend [$];
  logic [W-1:0] expq [$];
  logic [W-1:0] got  [$];
  logic [W-1:0] last_frame [4];
  int cyc = 0;
  int due = -1;
  int model_count = 0;

  always @(negedge clk) begin
    bit exp_v, exp_r;
    cyc++;
    if (!reset) begin
      pend.delete();
      expq.delete();
      due = -1;
      model_count = 0;
    end else begin
      if (due >= 0 && cyc == due) begin
        due = -1;
        check("dct_sample0", dct_sample0, last_frame[0]);
        check("dct_sample1", dct_sample1, last_frame[1]);
        check("dct_sample2", dct_sample2, last_frame[2]);
        check("dct_sample3", dct_sample3, last_frame[3]);
      end
      exp_v = (expq.size() > 0) && (due < 0);
      exp_r = (expq.size() == 0) && (due < 0);
      check("out_valid", out_valid, exp_v);
      check("in_ready", in_ready, exp_r);
      check("busy", busy, !exp_r);
      check("frame_count", frame_count, model_count[FCW-1:0]);
      if (exp_v && out_valid) begin
        check("out_data", out_data, expq[0]);
        check("out_last", out_last, expq.size() == 1);
      end
      if (abort) begin
        pend.delete();
        expq.delete();
        due = -1;
      end else begin
        if (in_valid && exp_r) begin
          pend.push_back(in_data);
          if (pend.size() == 4) begin
            for (int i = 0; i < 4; i++) last_frame[i] = pend[i];
            expq = '{pend[3], pend[2], pend[1], pend[0]};
            pend.delete();
            due = cyc + L + 1;
          end
        end
        if (out_ready && exp_v) begin
          got.push_back(out_data);
          void'(expq.pop_front());
          if (expq.size() == 0) model_count = (model_count + 1) % (1 << FCW);
        end
      end
    end
  end

  typedef struct {
    logic [W-1:0] s [4];
    int           gap;
    logic [7:0]   pat;
    logic [W-1:0] e [4];
  } vec_t;
  vec_t tbl [7];
  int   exp_fc;

  task automatic set_vec(input int i, input logic [W-1:0] s0, s1, s2, s3, input int gap,
                         input logic [7:0] pat, input logic [W-1:0] e0, e1, e2, e3);
    tbl[i].s[0] = s0; tbl[i].s[1] = s1; tbl[i].s[2] = s2; tbl[i].s[3] = s3;
    tbl[i].gap  = gap;
    tbl[i].pat  = pat;
    tbl[i].e[0] = e0; tbl[i].e[1] = e1; tbl[i].e[2] = e2; tbl[i].e[3] = e3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [W-1:0] v, input int gap);
    bit ok = 0;
    in_data  = v;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("in_ready_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic feed(input int idx);
    for (int i = 0; i < 4; i++) send_sample(tbl[idx].s[i], tbl[idx].gap);
  endtask

  // out_ready follows the pattern, advancing one bit per cycle that out_valid is high.
  task automatic drain(input logic [7:0] pat);
    int k = 0;
    bit was_v;
    for (int t = 0; t < 200 && got.size() < 4; t++) begin
      out_ready = pat[k % 8];
      was_v = out_valid;
      step();
      if (was_v) k++;
    end
    if (got.size() < 4) check("drain_timeout", got.size(), 4);
    out_ready = 1'b0;
  endtask

  task automatic run_frame(input int idx);
    got.delete();
    out_ready = 1'b0;
    feed(idx);
    drain(tbl[idx].pat);
    for (int i = 0; i < 4; i++) check($sformatf("vec%0d_coef%0d", idx, i), got[i], tbl[idx].e[i]);
    exp_fc++;
    step();
    check($sformatf("vec%0d_frame_count", idx), frame_count, exp_fc[FCW-1:0]);
  endtask

  initial begin
    bit ok;
    set_vec(0, 3, 9, 15, 21, 0, 8'hFF, 21, 15, 9, 3);
    set_vec(1, 3, 9, 15, 21, 0, 8'hE9, 21, 15, 9, 3);
    set_vec(2, 3, 9, 15, 21, 2, 8'hFF, 21, 15, 9, 3);
    set_vec(3, 16'hFFFF, 16'h8000, 16'h0000, 16'h7FFF, 1, 8'h55, 16'h7FFF, 16'h0000, 16'h8000, 16'hFFFF);
    set_vec(4, 1, 2, 3, 4, 0, 8'hFF, 4, 3, 2, 1);
    set_vec(5, 5, 6, 7, 8, 0, 8'hFF, 8, 7, 6, 5);
    set_vec(6, 100, 200, 300, 400, 0, 8'hB3, 400, 300, 200, 100);

    reset = 1'b0; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_dct_sample0", dct_sample0, 0);
    check("rst_dct_sample3", dct_sample3, 0);
    reset = 1'b1;
    exp_fc = 0;
    step();

    for (int v = 0; v < 4; v++) run_frame(v);

    // Abort during DRAIN after two transfers, then a fresh frame.
    got.delete();
    out_ready = 1'b0;
    feed(0);
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      if (out_valid) begin ok = 1; break; end
      step();
    end
    if (!ok) check("abort_drain_timeout", 0, 1);
    out_ready = 1'b1;
    step();
    step();
    check("abort_drain_two_xfers", got.size(), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_drain_out_valid", out_valid, 0);
    check("abort_drain_in_ready", in_ready, 1);
    check("abort_drain_frame_count", frame_count, exp_fc[FCW-1:0]);
    check("abort_drain_no_extra", got.size(), 2);
    run_frame(4);

    // Abort in FILL after two samples; the next frame must start at index 0.
    send_sample(16'hAAAA, 0);
    send_sample(16'hBBBB, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    run_frame(5);
    check("fill_abort_s0", dct_sample0, 5);
    check("fill_abort_s1", dct_sample1, 6);
    check("fill_abort_s2", dct_sample2, 7);
    check("fill_abort_s3", dct_sample3, 8);

    // Async reset while waiting on the core.
    out_ready = 1'b0;
    feed(0);
    check("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_frame_count", frame_count, 0);
    check("async_rst_dct_sample3", dct_sample3, 0);
    step();
    reset = 1'b1;
    exp_fc = 0;
    step();
    run_frame(6);

    // Randomized traffic; the model above checks every cycle.
    for (int t = 0; t < 3000; t++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      abort     = ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dct_t2_sequencer.md
Name: dct_t2_sequencer

Overview:
- Frames a serial 16-bit sample stream into 4-sample blocks and drives them into the parallel dct_t2 core.
- Waits a fixed core latency, captures the four coefficients, then streams them out serially with valid/ready handshakes.
- Sits between the polyphase/sample front end and the downstream quantiser in the mp3 datapath.

Parameters:
- WIDTH, 16, sample and coefficient bit width.
- DCT_LATENCY, 2, clock edges from dct_sample* change to dct_out* valid; legal range 1..15.
- FRAME_CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  WIDTH  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a sample this cycle.
- abort  in  1  synchronous frame discard.
- dct_sample0..dct_sample3  out  WIDTH each  registered operands to dct_t2 sample0..3.
- dct_out0..dct_out3  in  WIDTH each  from dct_t2 out_sample0..3.
- out_data  out  WIDTH  serial coefficient.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high with the 4th coefficient of a frame.
- busy  out  1  state != FILL.
- frame_count  out  FRAME_CNT_W  completed (fully drained) frames, wraps.

Behaviour:
- Reset (reset=0, async):
  - State FILL; fill index, wait counter and drain index cleared.
  - dct_sample0..3, result registers and frame_count cleared to 0.
  - out_valid=0, out_last=0, busy=0, in_ready=1.
- States: FILL -> WAIT -> DRAIN -> FILL.
- FILL:
  - in_ready=1.
  - Each edge with in_valid&&in_ready writes in_data to dct_sample[fill_idx]; fill_idx increments.
  - On the edge accepting fill_idx==3: go to WAIT, load wait counter with DCT_LATENCY-1, reset fill_idx.
- WAIT:
  - in_ready=0, busy=1; dct_sample* held stable.
  - Counter decrements each edge.
  - On the edge where the counter is 0: capture dct_out0..3 into result regs, go to DRAIN, drain_idx=0.
  - Capture therefore happens exactly DCT_LATENCY edges after the 4th sample's accepting edge (edge t accepts, capture at t+DCT_LATENCY).
- DRAIN:
  - out_valid=1; out_data=result[drain_idx]; out_last=(drain_idx==3).
  - Outputs are registered/state-derived, stable while out_ready=0.
  - On out_valid&&out_ready: drain_idx increments.
  - On the transfer with drain_idx==3: frame_count increments (modulo 2^FRAME_CNT_W), go to FILL; in_ready=1 from the next cycle.
- No input overlap: in_ready=0 throughout WAIT and DRAIN. No sample is dropped; the upstream stalls.
- abort=1 at an edge, in any state:
  - Go to FILL, clear fill_idx and drain_idx; out_valid falls after that edge.
  - frame_count unchanged; dct_sample* and result regs keep their values.
  - abort has priority over a same-cycle input or output handshake; that transfer is not counted.
- Back-to-back: the 4th out transfer and the 1st in transfer cannot share a cycle. Minimum frame period is 4 + DCT_LATENCY + 4 cycles.
- Reset asserted mid-frame returns all state to reset values immediately; a partial frame is lost.

Test Plan:
- Basic frame, DCT_LATENCY=2, bench stub drives dct_outk = dct_sample(3-k) delayed 2 edges, out_ready=1:
  - Feed 3,9,15,21 continuously -> dct_sample0..3=3,9,15,21.
  - in_ready low for 6 cycles; out_data 21,15,9,3 on consecutive cycles.
  - out_last only on 3; frame_count 0->1.
- Backpressure: same frame, out_ready toggled 1,0,0,1,0,1,1 -> exactly 4 transfers 21,15,9,3 in order; out_data held during stalls; busy high until the last transfer.
- Gapped input: in_valid high only every 3rd cycle with 3,9,15,21 -> capture occurs exactly 2 edges after the edge accepting 21; no earlier out_valid.
- Abort during DRAIN after 2 transfers:
  - out_valid low the next cycle; frame_count stays 1; in_ready=1.
  - A fresh frame 1,2,3,4 yields 4,3,2,1.
- Abort in FILL after 2 samples, then feed 5,6,7,8 -> dct_sample0..3=5,6,7,8 (no stale indexing).
- Async reset asserted during WAIT -> outputs immediately at reset values; frame_count=0; in_ready=1 after release; next frame processes normally.
